if_fetch_queue: RTL and testbench

//  Next-generation instruction-fetch stage. Issues sequential fetch requests to instruction memory

---
 rtl/if_fetch_queue.sv | 193 +++++++++++++++++++
 tb/tb_if_fetch_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: sequential imem requests, in-order responses, FQ_DEPTH-entry {pc, inst}
// queue toward ID, with redirect flush. Optional feature: define IF_MISALIGN_TRAP_EN.
module if_fetch_queue #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     FQ_DEPTH  = 4,
  parameter int unsigned     MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_redirect,
  input  logic [XLEN-1:0] id_target,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
`ifdef IF_MISALIGN_TRAP_EN
  output logic            out_misalign,
`endif
  output logic [XLEN-1:0] out_inst
);

  localparam int unsigned     PW      = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  // Counters carry one spare bit so count+outst never overflows in the reserve compare.
  localparam int unsigned     CW      = PW + 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(XLEN / 8);
  localparam logic [CW-1:0]   DEPTH_C = CW'(FQ_DEPTH);
  localparam logic [CW-1:0]   OUTST_C = CW'(MAX_OUTST);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   kill_q, kill_d;

  logic [XLEN-1:0] pc_mem_q   [FQ_DEPTH];
  logic [XLEN-1:0] inst_mem_q [FQ_DEPTH];

  logic            redirect;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] redir_target;
  logic            fetch_halt;
  logic            inject;
  logic            req_fire;
  logic            rsp_fire;
  logic            rsp_keep;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] push_inst;

  assign redirect   = ex_redirect | id_redirect;
  assign raw_target = ex_redirect ? ex_target : id_target;

`ifdef IF_MISALIGN_TRAP_EN
  localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);

  logic            halt_q, halt_d;
  logic            pend_q, pend_d;
  logic            redir_misaligned;
  logic            mis_mem_q [FQ_DEPTH];

  assign redir_target     = raw_target;
  assign redir_misaligned = |raw_target[1:0];
  assign fetch_halt       = halt_q;
  // Once every stale response has been discarded the trap entry is the only thing left to queue.
  assign inject           = pend_q && (kill_q == '0) && !redirect;
  assign push_inst        = inject ? NOP_INST : imem_rsp_data;

  always_comb begin
    halt_d = halt_q;
    pend_d = pend_q;
    if (redirect) begin
      halt_d = redir_misaligned;
      pend_d = redir_misaligned;
    end else if (inject) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mis_mem_q[tail_q] <= inject;
    end
  end

  assign out_misalign = out_valid & mis_mem_q[head_q];
`else
  assign redir_target = raw_target & ~XLEN'(3);
  assign fetch_halt   = 1'b0;
  assign inject       = 1'b0;
  assign push_inst    = imem_rsp_data;
`endif

  // Reserve a queue slot for every in-flight request so a response can always be accepted.
  assign imem_req_valid = !rst && !redirect && !fetch_halt
                          && ((count_q + outst_q) < DEPTH_C)
                          && (outst_q < OUTST_C);
  assign imem_req_addr  = pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && (outst_q != '0);
  assign rsp_keep = rsp_fire && (kill_q == '0);
  assign push     = (rsp_keep || inject) && !redirect;
  assign pop      = out_valid && out_ready && !redirect;

  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? pc_mem_q[head_q]   : '0;
  assign out_inst  = out_valid ? inst_mem_q[head_q] : '0;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    outst_d  = outst_q + CW'(req_fire) - CW'(rsp_fire);
    kill_d   = kill_q;

    if (redirect) begin
      pc_d     = redir_target;
      rsp_pc_d = redir_target;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      // Everything still in flight after this edge belongs to the abandoned path.
      kill_d   = outst_q - CW'(rsp_fire) + CW'(req_fire);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + PC_STEP;
      end
      if (rsp_fire && (kill_q != '0)) begin
        kill_d = kill_q - CW'(1);
      end
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + PC_STEP;
      end
      if (push) begin
        tail_d = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      outst_q  <= '0;
      kill_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      kill_q   <= kill_d;
    end
  end

  // Responses return in order, so the pc of a kept response is simply the running rsp_pc_q.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]   <= rsp_pc_q;
      inst_mem_q[tail_q] <= push_inst;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with an in-order variable-latency imem model.
// Build with IF_MISALIGN_TRAP_EN defined to exercise the misalign trap path.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_redirect;
  logic [31:0] id_target;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
`ifdef IF_MISALIGN_TRAP_EN
  logic        out_misalign;
`endif

  always #5 clk = ~clk;

  if_fetch_queue #(
    .XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(4), .MAX_OUTST(2)
  ) dut (
    .clk(clk), .rst(rst),
    .id_redirect(id_redirect), .id_target(id_target),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
`ifdef IF_MISALIGN_TRAP_EN
    .out_misalign(out_misalign),
`endif
    .out_inst(out_inst)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // imem model state and transaction logs
  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] req_log  [$];
  logic [31:0] pop_pc   [$];
  logic [31:0] pop_inst [$];
  logic        pop_mis  [$];

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq_addr.delete();
        mq_due.delete();
      end else begin
        if (imem_rsp_valid) begin
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
          mq_addr.push_back(imem_req_addr);
          mq_due.push_back(cyc + lat);
          req_log.push_back(imem_req_addr);
        end
        if (out_valid && out_ready && !id_redirect && !ex_redirect) begin
          pop_pc.push_back(out_pc);
          pop_inst.push_back(out_inst);
`ifdef IF_MISALIGN_TRAP_EN
          pop_mis.push_back(out_misalign);
`else
          pop_mis.push_back(1'b0);
`endif
        end
      end
      cyc++;
      #1;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = inst_of(mq_addr[0]);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc.delete();
    pop_inst.delete();
    pop_mis.delete();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    id_redirect = 1'b0;
    ex_redirect = 1'b0;
    tick(3);
    check({tag, "_rst_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_rst_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rst_out_pc"}, out_pc, 32'd0);
    check({tag, "_rst_out_inst"}, out_inst, 32'd0);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic redirect(input logic use_id, input logic [31:0] id_t,
                          input logic use_ex, input logic [31:0] ex_t, input string tag);
    id_redirect = use_id;
    id_target   = id_t;
    ex_redirect = use_ex;
    ex_target   = ex_t;
    #1;
    check({tag, "_redir_req_valid"}, 32'(imem_req_valid), 32'd0);
    tick(1);
    id_redirect = 1'b0;
    ex_redirect = 1'b0;
    clear_logs();
  endtask

  task automatic expect_pops(input string tag, input int n, input logic [31:0] base);
    check({tag, "_npop_ok"}, 32'(pop_pc.size() >= n), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i < pop_pc.size()) begin
        check($sformatf("%s_pc%0d", tag, i), pop_pc[i], base + 32'(4 * i));
        check($sformatf("%s_inst%0d", tag, i), pop_inst[i], inst_of(base + 32'(4 * i)));
      end
    end
  endtask

  initial begin
    logic seen;
    rst = 1'b1;
    id_redirect = 1'b0; id_target = '0;
    ex_redirect = 1'b0; ex_target = '0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;

    // 1: streaming fetch from reset
    lat = 1;
    do_reset("t1");
    tick(12);
    check("t1_nreq_ok", 32'(req_log.size() >= 3), 32'd1);
    for (int i = 0; i < 3; i++)
      if (i < req_log.size()) check($sformatf("t1_req%0d", i), req_log[i], 32'(4 * i));
    expect_pops("t1", 3, 32'h0);

    // 2: ID stall fills the queue, then drains in order
    out_ready = 1'b0;
    do_reset("t2");
    tick(10);
    check("t2_nreq", 32'(req_log.size()), 32'd4);
    check("t2_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    tick(15);
    expect_pops("t2", 6, 32'h0);

    // 3: simultaneous ID and EX redirect, EX wins
    do_reset("t3");
    tick(6);
    redirect(1'b1, 32'h100, 1'b1, 32'h200, "t3");
    tick(10);
    check("t3_nreq_ok", 32'(req_log.size() >= 1), 32'd1);
    if (req_log.size() >= 1) check("t3_first_req", req_log[0], 32'h200);
    seen = 1'b0;
    foreach (req_log[i]) if (req_log[i] == 32'h100) seen = 1'b1;
    check("t3_no_0x100", 32'(seen), 32'd0);
    expect_pops("t3", 3, 32'h200);

    // 4: redirect with two requests in flight
    lat = 4;
    do_reset("t4");
    tick(2);
    check("t4_nreq_before", 32'(req_log.size()), 32'd2);
    redirect(1'b0, 32'h0, 1'b1, 32'h40, "t4");
    tick(30);
    if (req_log.size() >= 1) check("t4_first_req", req_log[0], 32'h40);
    expect_pops("t4", 2, 32'h40);

    // 5: imem backpressure holds the request stable
    lat = 1;
    do_reset("t5");
    tick(3);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check($sformatf("t5_addr_c%0d", i), imem_req_addr, 32'hC);
      check($sformatf("t5_valid_c%0d", i), 32'(imem_req_valid), 32'd1);
    end
    check("t5_nreq_stall", 32'(req_log.size()), 32'd3);
    imem_req_ready = 1'b1;
    tick(15);
    expect_pops("t5", 8, 32'h0);

    // 6: misaligned redirect target
    do_reset("t6");
    tick(4);
    redirect(1'b0, 32'h0, 1'b1, 32'h42, "t6");
    tick(10);
`ifdef IF_MISALIGN_TRAP_EN
    check("t6_npop", 32'(pop_pc.size()), 32'd1);
    if (pop_pc.size() >= 1) begin
      check("t6_pc", pop_pc[0], 32'h42);
      check("t6_inst", pop_inst[0], 32'h13);
      check("t6_mis", 32'(pop_mis[0]), 32'd1);
    end
    check("t6_nreq", 32'(req_log.size()), 32'd0);
    check("t6_req_valid", 32'(imem_req_valid), 32'd0);
    check("t6_out_valid", 32'(out_valid), 32'd0);
`else
    if (req_log.size() >= 1) check("t6_first_req", req_log[0], 32'h40);
    else check("t6_nreq_ok", 32'(req_log.size()), 32'd1);
    expect_pops("t6", 2, 32'h40);
    if (pop_mis.size() >= 1) check("t6_mis", 32'(pop_mis[0]), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
